// File: rtl/toffoli_seq_if.sv
// toffoli_seq_if: programming, start and result signals of the sequenced Toffoli engine.
interface toffoli_seq_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int IW = $clog2(WIDTH);
   localparam int AW = $clog2(DEPTH);
   localparam int GW = 2 + 3 * IW;
   logic prog_we;
   logic [AW-1:0] prog_addr;
   logic [GW-1:0] prog_data;
   logic [AW:0] prog_len;
   logic start;
   logic dir;
   logic [WIDTH-1:0] data_in;
   logic busy;
   logic done;
   logic [WIDTH-1:0] data_out;
   modport master (
      output prog_we, prog_addr, prog_data, prog_len, start, dir, data_in,
      input  busy, done, data_out
   );
   modport slave (
      input  prog_we, prog_addr, prog_data, prog_len, start, dir, data_in,
      output busy, done, data_out
   );
endinterface

// File: rtl/toffoli_seq.sv
// toffoli_seq: applies a stored NOT/CNOT/CCNOT list one gate per clock, forward or reverse.
// Define TOFF_SEQ_ILLEGAL_EN to add the sticky illegal_o flag for aliased/out-of-range gates.
module toffoli_seq #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
`ifdef TOFF_SEQ_ILLEGAL_EN
   output logic illegal_o,
`endif
   toffoli_seq_if.slave bus
);
   localparam int IW = $clog2(WIDTH);
   localparam int AW = $clog2(DEPTH);
   localparam int GW = 2 + 3 * IW;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q;
   logic [GW-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] s_q, s_d, dout_q;
   logic [AW-1:0] ptr_q;
   logic [AW:0] rem_q, len;
   logic dir_q, busy_q, done_q, bad, nop, flip;
   logic [1:0] ty;
   logic [IW-1:0] t, b, a;

   // Aliased targets would break self-inverse behaviour, so they degrade to NOP.
   always_comb begin
      {ty, t, b, a} = mem_q[ptr_q];
      bad = ty != 2'b11 && (t == a || (ty == 2'b10 && t == b) ||
            int'(t) >= WIDTH || int'(a) >= WIDTH || int'(b) >= WIDTH);
      nop = ty == 2'b11 || bad;
      flip = ty == 2'b00 ? 1'b1 : ty == 2'b01 ? s_q[a] : s_q[a] & s_q[b];
      s_d = s_q;
      if (!nop) s_d[t] = s_q[t] ^ flip;
      len = bus.prog_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : bus.prog_len;
   end

   always_ff @(posedge clk)
      if (state_q == IDLE && bus.prog_we) mem_q[bus.prog_addr] <= bus.prog_data;

   // A zero-length run spends two cycles in DONE so done still lands after E1.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         s_q <= '0;
         ptr_q <= '0;
         rem_q <= '0;
         dir_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dout_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.start) begin
               s_q <= bus.data_in;
               dir_q <= bus.dir;
               ptr_q <= bus.dir ? AW'(len - 1'b1) : '0;
               rem_q <= len;
               busy_q <= 1'b1;
               state_q <= len == '0 ? DONE : RUN;
            end
            RUN: begin
               s_q <= s_d;
               ptr_q <= dir_q ? ptr_q - 1'b1 : ptr_q + 1'b1;
               rem_q <= rem_q - 1'b1;
               if (rem_q == (AW+1)'(1)) begin
                  state_q <= DONE;
                  done_q <= 1'b1;
                  dout_q <= s_d;
               end
            end
            default: if (done_q) begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state_q <= IDLE;
            end else begin
               done_q <= 1'b1;
               dout_q <= s_q;
            end
         endcase
      end

`ifdef TOFF_SEQ_ILLEGAL_EN
   logic illegal_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) illegal_q <= 1'b0;
      else if (state_q == IDLE && bus.start) illegal_q <= 1'b0;
      else if (state_q == RUN && bad) illegal_q <= 1'b1;
   assign illegal_o = illegal_q;
`endif

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.data_out = dout_q;
endmodule

// File: tb/tb_toffoli_seq.sv
// tb_toffoli_seq: directed and randomized runs of toffoli_seq against a gate-list reference model.
module tb_toffoli_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   int gm [16];
   toffoli_seq_if #(.WIDTH(8), .DEPTH(16)) bus ();
`ifdef TOFF_SEQ_ILLEGAL_EN
   logic illegal;
   toffoli_seq #(.WIDTH(8), .DEPTH(16)) dut (.clk(clk), .rst(rst), .illegal_o(illegal), .bus(bus));
`else
   toffoli_seq #(.WIDTH(8), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Walk the gate list as written, applying each gate's rule to a bit vector.
   function automatic logic [7:0] model(input int len, input bit d, input logic [7:0] din);
      int n, w, ty, t, b, a;
      logic [7:0] s;
      n = len > 16 ? 16 : len;
      s = din;
      for (int k = 0; k < n; k++) begin
         w = gm[d ? n - 1 - k : k];
         ty = (w >> 9) & 3;
         t = (w >> 6) & 7;
         b = (w >> 3) & 7;
         a = w & 7;
         if (ty == 3 || t == a || (ty == 2 && t == b)) continue;
         if (ty == 0) s[t] = !s[t];
         else if (ty == 1) s[t] = s[t] ^ s[a];
         else s[t] = s[t] ^ (s[a] & s[b]);
      end
      return s;
   endfunction

   task automatic prog(input int addr, input int w);
      @(negedge clk);
      bus.prog_we = 1'b1;
      bus.prog_addr = addr[3:0];
      bus.prog_data = w[10:0];
      @(negedge clk);
      bus.prog_we = 1'b0;
      gm[addr] = w & 11'h7FF;
   endtask

   task automatic run(input int len, input bit d, input logic [7:0] din, input bit inject);
      logic [7:0] exp;
      int n, lim;
      exp = model(len, d, din);
      lim = len == 0 ? 1 : (len > 16 ? 16 : len);
      @(negedge clk);
      bus.start = 1'b1;
      bus.dir = d;
      bus.data_in = din;
      bus.prog_len = len[4:0];
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      if (inject) begin
         bus.start = 1'b1;
         bus.data_in = ~din;
         bus.prog_we = 1'b1;
         bus.prog_addr = 4'd0;
         bus.prog_data = ~gm[0][10:0];
      end
      n = 0;
      while (!bus.done && n < 40) begin
         chk("busy_run", bus.busy, 1);
         @(posedge clk);
         @(negedge clk);
         bus.start = 1'b0;
         bus.prog_we = 1'b0;
         n++;
      end
      chk("latency", n, lim);
      chk("data_out", bus.data_out, exp);
      chk("busy_done", bus.busy, 1);
      @(negedge clk);
      chk("done_pulse", bus.done, 0);
      chk("busy_after", bus.busy, 0);
      chk("data_hold", bus.data_out, exp);
   endtask

   initial begin
      logic [7:0] x, din;
      int w;
      bus.prog_we = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      bus.prog_len = '0;
      bus.start = 1'b0;
      bus.dir = 1'b0;
      bus.data_in = '0;
      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_data", bus.data_out, 0);
      @(negedge clk);
      rst = 1'b0;
      // Single CCNOT a=0 b=1 t=2.
      prog(0, 32'h488);
      run(1, 1'b0, 8'h03, 1'b0);
      chk("ccnot_const", bus.data_out, 8'h07);
      // Round trip over four random gates.
      for (int i = 0; i < 4; i++) prog(i, $urandom_range(0, 2047));
      run(4, 1'b0, 8'hA5, 1'b0);
      x = bus.data_out;
      run(4, 1'b1, x, 1'b0);
      chk("round_trip", bus.data_out, 8'hA5);
      // Zero-length run passes the operand straight through.
      run(0, 1'b0, 8'h5C, 1'b0);
      chk("len0", bus.data_out, 8'h5C);
      // Oversized prog_len clamps to the full list.
      for (int i = 0; i < 16; i++) prog(i, $urandom_range(0, 2047));
      run(20, 1'b0, 8'h3C, 1'b0);
      run(20, 1'b1, 8'hC3, 1'b0);
      // start and prog_we mid-run are ignored.
      run(4, 1'b0, 8'h96, 1'b1);
      run(4, 1'b0, 8'h96, 1'b0);
      // Reset at E2 aborts the run; memory survives.
      din = 8'h69;
      @(negedge clk);
      bus.start = 1'b1;
      bus.dir = 1'b0;
      bus.data_in = din;
      bus.prog_len = 5'd4;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_data", bus.data_out, 0);
      @(negedge clk);
      rst = 1'b0;
      run(4, 1'b0, din, 1'b0);
      // Random runs, each followed by its reverse to restore the operand.
      for (int i = 0; i < 8; i++) begin
         w = $urandom_range(0, 20);
         din = 8'($urandom);
         run(w, 1'($urandom), din, 1'b0);
         x = bus.data_out;
         run(w, !bus.dir, x, 1'b0);
         chk("rand_restore", bus.data_out, din);
      end
`ifdef TOFF_SEQ_ILLEGAL_EN
      prog(0, 32'h2C3);
      run(1, 1'b0, 8'hFF, 1'b0);
      chk("illegal_data", bus.data_out, 8'hFF);
      chk("illegal_set", illegal, 1);
      run(0, 1'b0, 8'h11, 1'b0);
      chk("illegal_clr", illegal, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
